zc_spi_master: RTL and testbench

SPI mode-0 initiator that drives the SD card interface on behalf of the TSConf Z-controller ports. It shifts one byte out on SD_SI while shifting one byte in from SD_SO per request, with a software-controlled chip select. It sits between the tsconf port decoder and the top-level SD mux, which selects between the physical card and the virtual sd_card responder. It is the master end of the link whose slave end is sd_card.

---
 rtl/zc_spi_master.sv | 122 ++++++++++++
 tb/tb_zc_spi_master.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/zc_spi_master.sv
// SPI mode-0 initiator for the Z-controller SD interface.
// Each request sends one byte MSB first and captures one byte from the card.
module zc_spi_master #(
    parameter int SLOW_DIV = 35,
    parameter int FAST_DIV = 1
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       ce,
    input  logic       slow,
    input  logic       cs_wr,
    input  logic       cs_din,
    input  logic       start,
    input  logic [7:0] tx_data,
    output logic [7:0] rx_data,
    output logic       busy,
    output logic       done,
    output logic       SD_CS_N,
    output logic       SD_CLK,
    output logic       SD_SI,
    input  logic       SD_SO
);

    // state   | meaning
    // IDLE    | no transfer, SD_CLK low, SD_SI high
    // LOW     | SD_CLK low phase, current bit driven on SD_SI
    // HIGH    | SD_CLK high phase, card bit already sampled into rxbit
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOW  = 2'd1;
    localparam logic [1:0] ST_HIGH = 2'd2;

    localparam logic [7:0] SLOW_HALF = 8'(SLOW_DIV);
    localparam logic [7:0] FAST_HALF = 8'(FAST_DIV);

    logic [1:0] state;
    logic [7:0] shift;
    logic [7:0] half;
    logic [7:0] div;
    logic [2:0] cnt;
    logic       rxbit;
    logic [7:0] sel_half;

    assign sel_half = slow ? SLOW_HALF : FAST_HALF;
    assign SD_SI    = (state == ST_IDLE) ? 1'b1 : shift[7];

    // Chip select is independent of the shifter so software can toggle it at any time.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            SD_CS_N <= 1'b1;
        end else if (cs_wr) begin
            SD_CS_N <= cs_din;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            shift   <= 8'hFF;
            half    <= FAST_HALF;
            div     <= 8'd0;
            cnt     <= 3'd0;
            rxbit   <= 1'b1;
            SD_CLK  <= 1'b0;
            rx_data <= 8'hFF;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    SD_CLK <= 1'b0;
                    if (start) begin
                        shift <= tx_data;
                        half  <= sel_half;
                        div   <= sel_half - 8'd1;
                        cnt   <= 3'd0;
                        busy  <= 1'b1;
                        state <= ST_LOW;
                    end
                end
                ST_LOW: begin
                    if (ce) begin
                        if (div != 8'd0) begin
                            div <= div - 8'd1;
                        end else begin
                            div    <= half - 8'd1;
                            SD_CLK <= 1'b1;
                            rxbit  <= SD_SO;
                            state  <= ST_HIGH;
                        end
                    end
                end
                ST_HIGH: begin
                    if (ce) begin
                        if (div != 8'd0) begin
                            div <= div - 8'd1;
                        end else begin
                            SD_CLK <= 1'b0;
                            shift  <= {shift[6:0], rxbit};
                            cnt    <= cnt + 3'd1;
                            if (cnt == 3'd7) begin
                                rx_data <= {shift[6:0], rxbit};
                                done    <= 1'b1;
                                busy    <= 1'b0;
                                state   <= ST_IDLE;
                            end else begin
                                div   <= half - 8'd1;
                                state <= ST_LOW;
                            end
                        end
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    SD_CLK <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_zc_spi_master.sv
// Directed self-checking bench for zc_spi_master.
// Loop-back and fixed-MISO transfers, ignored start, CS control, reset mid-byte.
module tb_zc_spi_master;

    logic       clk_sys = 1'b0;
    logic       reset_n = 1'b0;
    logic       ce = 1'b1;
    logic       slow = 1'b0;
    logic       cs_wr = 1'b0;
    logic       cs_din = 1'b1;
    logic       start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic [7:0] rx_data;
    logic       busy, done, sd_cs_n, sd_clk, sd_si, sd_so;
    logic       lb = 1'b1;
    logic       so_val = 1'b0;

    assign sd_so = lb ? sd_si : so_val;

    zc_spi_master #(.SLOW_DIV(35), .FAST_DIV(1)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .ce(ce), .slow(slow),
        .cs_wr(cs_wr), .cs_din(cs_din), .start(start), .tx_data(tx_data),
        .rx_data(rx_data), .busy(busy), .done(done), .SD_CS_N(sd_cs_n),
        .SD_CLK(sd_clk), .SD_SI(sd_si), .SD_SO(sd_so)
    );

    always #5 clk_sys = ~clk_sys;

    int pass_cnt = 0, fail_cnt = 0, total_cnt = 0;
    int cyc = 0, rises = 0, falls = 0, dones = 0, bfalls = 0, ce_ticks = 0;
    int rise_t0 = 0, rise_t1 = 0, fall_t0 = 0;
    int ce_mode = 0, ce_ph = 0, n = 0;
    logic [7:0] si_bits = 8'h00;
    logic clk_prev = 1'b0, busy_prev = 1'b0, ce_edge = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        rises = 0; falls = 0; dones = 0; bfalls = 0; ce_ticks = 0; si_bits = 8'h00;
    endtask

    // One clk_sys cycle; samples outputs 1 time unit after the edge.
    task automatic tick();
        ce_edge = ce;
        @(posedge clk_sys);
        #1;
        cyc++;
        if (ce_edge && busy_prev) ce_ticks++;
        if (sd_clk && !clk_prev) begin
            if (rises == 0) rise_t0 = cyc;
            if (rises == 1) rise_t1 = cyc;
            rises++;
            si_bits = {si_bits[6:0], sd_si};
        end
        if (!sd_clk && clk_prev) begin
            if (falls == 0) fall_t0 = cyc;
            falls++;
        end
        if (done) dones++;
        if (!busy && busy_prev) bfalls++;
        clk_prev  = sd_clk;
        busy_prev = busy;
        if (ce_mode == 0) ce = 1'b1;
        else begin
            ce_ph = (ce_ph == 2) ? 0 : ce_ph + 1;
            ce = (ce_ph == 0);
        end
    endtask

    task automatic start_xfer(input logic [7:0] d);
        tx_data = d; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // n counts cycles from the start cycle; bounded wait for done.
    task automatic wait_done(input int maxc, output int cnt_o);
        cnt_o = 1;
        while (!done && cnt_o < maxc) begin
            tick();
            cnt_o++;
        end
        chk("done_seen", {31'd0, done}, 32'd1);
    endtask

    initial begin
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        chk("rst_cs_n", {31'd0, sd_cs_n}, 32'd1);
        chk("rst_clk", {31'd0, sd_clk}, 32'd0);
        chk("rst_si", {31'd0, sd_si}, 32'd1);
        chk("rst_rx", {24'd0, rx_data}, 32'hFF);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);

        // Fast loop-back of A5
        clr(); lb = 1'b1; slow = 1'b0;
        start_xfer(8'hA5);
        chk("fast_busy_rise", {31'd0, busy}, 32'd1);
        wait_done(40, n);
        chk("fast_done_cycle", n, 17);
        chk("fast_rises", rises, 8);
        chk("fast_si_bits", {24'd0, si_bits}, 32'hA5);
        chk("fast_rx", {24'd0, rx_data}, 32'hA5);
        chk("fast_busy_end", {31'd0, busy}, 32'd0);
        tick();
        chk("fast_done_once", dones, 1);

        // Slow mode, ce every third cycle, MISO held low
        clr(); lb = 1'b0; so_val = 1'b0; slow = 1'b1; ce_mode = 1;
        start_xfer(8'hFF);
        slow = 1'b0;
        wait_done(2000, n);
        chk("slow_high_phase", fall_t0 - rise_t0, 105);
        chk("slow_low_phase", rise_t1 - fall_t0, 105);
        chk("slow_ce_ticks", ce_ticks, 560);
        chk("slow_rx", {24'd0, rx_data}, 32'h00);
        chk("slow_si_bits", {24'd0, si_bits}, 32'hFF);
        ce_mode = 0; ce = 1'b1;
        tick();

        // Second start mid-transfer must be ignored
        clr(); lb = 1'b1;
        start_xfer(8'h3C);
        repeat (4) tick();
        tx_data = 8'h00; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(40, n);
        repeat (4) tick();
        chk("ign_si_bits", {24'd0, si_bits}, 32'h3C);
        chk("ign_rx", {24'd0, rx_data}, 32'h3C);
        chk("ign_dones", dones, 1);
        chk("ign_busy_falls", bfalls, 1);

        // Chip select written mid-transfer
        clr();
        start_xfer(8'hC3);
        repeat (3) tick();
        cs_wr = 1'b1; cs_din = 1'b0;
        tick();
        cs_wr = 1'b0;
        chk("cs_low", {31'd0, sd_cs_n}, 32'd0);
        chk("cs_busy_kept", {31'd0, busy}, 32'd1);
        wait_done(40, n);
        chk("cs_rx", {24'd0, rx_data}, 32'hC3);
        cs_wr = 1'b1; cs_din = 1'b1;
        tick();
        cs_wr = 1'b0;
        chk("cs_high", {31'd0, sd_cs_n}, 32'd1);

        // Reset after the fourth rising SD_CLK edge
        clr();
        start_xfer(8'h00);
        n = 0;
        while (rises < 4 && n < 40) begin
            tick();
            n++;
        end
        chk("rstmid_rises", rises, 4);
        reset_n = 1'b0;
        #1;
        chk("rstmid_clk", {31'd0, sd_clk}, 32'd0);
        chk("rstmid_busy", {31'd0, busy}, 32'd0);
        chk("rstmid_rx", {24'd0, rx_data}, 32'hFF);
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (20) tick();
        chk("rstmid_no_done", dones, 0);
        chk("rstmid_rx_after", {24'd0, rx_data}, 32'hFF);
        clr();
        start_xfer(8'h5A);
        wait_done(40, n);
        chk("post_rst_rx", {24'd0, rx_data}, 32'h5A);
        chk("post_rst_si", {24'd0, si_bits}, 32'h5A);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
